xm_mem_ctrl: RTL and testbench

// - Memory access unit directly downstream of the XM control plane.
// - Consumes the plane's memory request: memEn/memRW/byteOp plus address and store data from the datapath.
// - Runs one handshaked transaction on a word-wide external bus, with byte-lane steering and timeout.
// - Returns memBusy/memWr to the control plane, so its controller stalls until the access completes.

---
 rtl/xm_pkg.sv | 20 ++
 rtl/xm_mem_lane.sv | 36 +++
 rtl/xm_mem_ctrl.sv | 158 +++++++++++++++
 tb/tb_xm_mem_ctrl.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/xm_pkg.sv
// Shared definitions for the XM memory access unit.
// - xm_mem_state_t : access FSM states (IDLE, BUS, DONE)
// - BE_WORD/BE_LO/BE_HI : byte-enable patterns for the two 8-bit lanes
// - MEM_RD/MEM_WR  : encoding of the read/write select from the control plane
package xm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    DONE = 2'd2
  } xm_mem_state_t;

  localparam logic [1:0] BE_WORD = 2'b11;
  localparam logic [1:0] BE_LO   = 2'b01;
  localparam logic [1:0] BE_HI   = 2'b10;

  localparam logic MEM_RD = 1'b0;
  localparam logic MEM_WR = 1'b1;

endpackage

// File: rtl/xm_mem_lane.sv
// Byte-lane steering for a 16-bit word bus (purely combinational).
// Ports:
//   i_byte  in   1     1 = byte access, 0 = word access
//   i_adr0  in   1     address bit 0 (selects the lane for byte accesses)
//   i_wdata in   WORD  store data (byte store uses [7:0])
//   i_rdata in   WORD  raw bus read data
//   o_be    out  2     byte enables
//   o_wdata out  WORD  bus write data (byte stores replicated on both lanes)
//   o_rdata out  WORD  load result (byte loads zero-extended)
module xm_mem_lane
  import xm_pkg::*;
#(
  parameter int WORD = 16
) (
  input  logic            i_byte,
  input  logic            i_adr0,
  input  logic [WORD-1:0] i_wdata,
  input  logic [WORD-1:0] i_rdata,
  output logic [1:0]      o_be,
  output logic [WORD-1:0] o_wdata,
  output logic [WORD-1:0] o_rdata
);

  always_comb begin
    o_be    = BE_WORD;
    o_wdata = i_wdata;
    o_rdata = i_rdata;
    if (i_byte) begin
      o_be    = i_adr0 ? BE_HI : BE_LO;
      // Replicating the byte lets the bus slave pick whichever lane is enabled.
      o_wdata = {i_wdata[7:0], i_wdata[7:0]};
      o_rdata = {8'h00, (i_adr0 ? i_rdata[WORD-1:8] : i_rdata[7:0])};
    end
  end

endmodule

// File: rtl/xm_mem_ctrl.sv
// Memory access unit downstream of the XM control plane. Accepts one request,
// runs a single handshaked transaction on the external word bus, and reports
// completion for exactly one DONE cycle.
// Ports:
//   clk_i, arst_i (async, active-low)
//   memEn_i/memRW_i/byteOp_i/adr_i/wrData_i : request from the control plane
//   memBusy_o : stall (combinational, rises in the request cycle)
//   memWr_o/alignErr_o/busErr_o : DONE-cycle pulses
//   rdData_o  : load result, valid from DONE until the next load completes
//   busReq_o/busWe_o/busAdr_o/busBe_o/busWdata_o : registered bus outputs
//   busRdata_i/busAck_i : bus response
module xm_mem_ctrl
  import xm_pkg::*;
#(
  parameter int WORD        = 16,
  parameter int ADDR        = 16,
  parameter int TIMEOUT_CYC = 15
) (
  input  logic            clk_i,
  input  logic            arst_i,
  input  logic            memEn_i,
  input  logic            memRW_i,
  input  logic            byteOp_i,
  input  logic [ADDR-1:0] adr_i,
  input  logic [WORD-1:0] wrData_i,
  output logic            memBusy_o,
  output logic            memWr_o,
  output logic [WORD-1:0] rdData_o,
  output logic            alignErr_o,
  output logic            busErr_o,
  output logic            busReq_o,
  output logic            busWe_o,
  output logic [ADDR-1:0] busAdr_o,
  output logic [1:0]      busBe_o,
  output logic [WORD-1:0] busWdata_o,
  input  logic [WORD-1:0] busRdata_i,
  input  logic            busAck_i
);

  // Last counter value before abort; unused when the timeout is disabled.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);

  xm_mem_state_t r_state;
  xm_mem_state_t w_state_next;

  logic            r_rw;
  logic            r_byte;
  logic            r_adr0;
  logic            r_err;
  logic [7:0]      r_cnt;
  logic [WORD-1:0] r_rdata;
  logic            r_bus_req;
  logic            r_bus_we;
  logic [ADDR-1:0] r_bus_adr;
  logic [1:0]      r_bus_be;
  logic [WORD-1:0] r_bus_wdata;

  logic            w_sel_byte;
  logic            w_sel_adr0;
  logic [1:0]      w_be;
  logic [WORD-1:0] w_wdata;
  logic [WORD-1:0] w_rdata;
  logic            w_timeout;

  // In IDLE the lane logic steers the incoming request (to load the bus
  // registers); afterwards it steers the read data using the latched request.
  assign w_sel_byte = (r_state == IDLE) ? byteOp_i : r_byte;
  assign w_sel_adr0 = (r_state == IDLE) ? adr_i[0] : r_adr0;

  xm_mem_lane #(.WORD(WORD)) u_lane (
    .i_byte  (w_sel_byte),
    .i_adr0  (w_sel_adr0),
    .i_wdata (wrData_i),
    .i_rdata (busRdata_i),
    .o_be    (w_be),
    .o_wdata (w_wdata),
    .o_rdata (w_rdata)
  );

  assign w_timeout = (TIMEOUT_CYC != 0) && (r_cnt == TO_LAST);

  always_ff @(posedge clk_i or negedge arst_i) begin
    if (!arst_i) r_state <= IDLE;
    else         r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (memEn_i) w_state_next = BUS;
      BUS:     if (busAck_i || w_timeout) w_state_next = DONE;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge arst_i) begin
    if (!arst_i) begin
      r_rw        <= 1'b0;
      r_byte      <= 1'b0;
      r_adr0      <= 1'b0;
      r_err       <= 1'b0;
      r_cnt       <= 8'd0;
      r_rdata     <= '0;
      r_bus_req   <= 1'b0;
      r_bus_we    <= 1'b0;
      r_bus_adr   <= '0;
      r_bus_be    <= 2'b00;
      r_bus_wdata <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (memEn_i) begin
            r_rw        <= memRW_i;
            r_byte      <= byteOp_i;
            r_adr0      <= adr_i[0];
            r_err       <= 1'b0;
            r_cnt       <= 8'd0;
            r_bus_req   <= 1'b1;
            r_bus_we    <= memRW_i;
            r_bus_adr   <= {adr_i[ADDR-1:1], 1'b0};
            r_bus_be    <= w_be;
            r_bus_wdata <= w_wdata;
          end
        end
        BUS: begin
          // Ack is checked first so a simultaneous timeout never flags an error.
          if (busAck_i) begin
            r_bus_req <= 1'b0;
            r_bus_we  <= 1'b0;
            if (r_rw == MEM_RD) r_rdata <= w_rdata;
          end else if (w_timeout) begin
            r_bus_req <= 1'b0;
            r_bus_we  <= 1'b0;
            r_rdata   <= '0;
            r_err     <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign memBusy_o  = ((r_state == IDLE) && memEn_i) || (r_state == BUS);
  assign memWr_o    = (r_state == DONE) && (r_rw == MEM_WR);
  assign alignErr_o = (r_state == DONE) && !r_byte && r_adr0;
  assign busErr_o   = (r_state == DONE) && r_err;
  assign rdData_o   = r_rdata;

  assign busReq_o   = r_bus_req;
  assign busWe_o    = r_bus_we;
  assign busAdr_o   = r_bus_adr;
  assign busBe_o    = r_bus_be;
  assign busWdata_o = r_bus_wdata;

endmodule

// File: tb/tb_xm_mem_ctrl.sv
// Directed bench for xm_mem_ctrl: DONE-cycle results are queued when each
// request is driven and checked when the access completes.
module tb_xm_mem_ctrl;

  logic        clk_i = 1'b0;
  logic        arst_i = 1'b0;
  logic        memEn_i = 1'b0;
  logic        memRW_i = 1'b0;
  logic        byteOp_i = 1'b0;
  logic [15:0] adr_i = '0;
  logic [15:0] wrData_i = '0;
  logic        memBusy_o, memWr_o, alignErr_o, busErr_o;
  logic [15:0] rdData_o;
  logic        busReq_o, busWe_o;
  logic [15:0] busAdr_o;
  logic [1:0]  busBe_o;
  logic [15:0] busWdata_o;
  logic [15:0] busRdata_i = '0;
  logic        busAck_i = 1'b0;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [15:0] rd;
    logic        wr;
    logic        al;
    logic        er;
    int          ncyc;
  } exp_t;
  exp_t sb[$];

  always #5 clk_i = ~clk_i;

  xm_mem_ctrl #(.WORD(16), .ADDR(16), .TIMEOUT_CYC(15)) dut (
    .clk_i(clk_i), .arst_i(arst_i),
    .memEn_i(memEn_i), .memRW_i(memRW_i), .byteOp_i(byteOp_i),
    .adr_i(adr_i), .wrData_i(wrData_i),
    .memBusy_o(memBusy_o), .memWr_o(memWr_o), .rdData_o(rdData_o),
    .alignErr_o(alignErr_o), .busErr_o(busErr_o),
    .busReq_o(busReq_o), .busWe_o(busWe_o), .busAdr_o(busAdr_o),
    .busBe_o(busBe_o), .busWdata_o(busWdata_o),
    .busRdata_i(busRdata_i), .busAck_i(busAck_i)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // One access. ack_after = BUS-cycle index in which ack is raised (-1: never).
  task automatic access(input string name, input logic rw, input logic bo,
                        input logic [15:0] adr, input logic [15:0] wd,
                        input logic [15:0] rdat, input int ack_after,
                        input logic [15:0] e_badr, input logic [1:0] e_be,
                        input logic [15:0] e_bwd, input logic chk_wd,
                        input logic [15:0] e_rd, input logic e_al,
                        input logic e_er, input int e_ncyc);
    exp_t e;
    int   n;
    e.rd = e_rd; e.wr = rw; e.al = e_al; e.er = e_er; e.ncyc = e_ncyc;
    @(posedge clk_i); #1;
    memEn_i = 1'b1; memRW_i = rw; byteOp_i = bo; adr_i = adr; wrData_i = wd;
    sb.push_back(e);
    @(negedge clk_i);
    chk({name, ".busy_req"}, {31'd0, memBusy_o}, 32'd1);
    @(posedge clk_i); #1;
    n = 0;
    while (n < 40) begin
      busAck_i   = (n == ack_after);
      busRdata_i = (n == ack_after) ? rdat : 16'hDEAD;
      @(negedge clk_i);
      if (n == 0 || n == ack_after) begin
        chk({name, ".busy_bus"}, {31'd0, memBusy_o}, 32'd1);
        chk({name, ".req"},  {31'd0, busReq_o}, 32'd1);
        chk({name, ".we"},   {31'd0, busWe_o},  {31'd0, rw});
        chk({name, ".adr"},  {16'd0, busAdr_o}, {16'd0, e_badr});
        chk({name, ".be"},   {30'd0, busBe_o},  {30'd0, e_be});
        if (chk_wd) chk({name, ".wdata"}, {16'd0, busWdata_o}, {16'd0, e_bwd});
      end
      @(posedge clk_i); #1;
      busAck_i = 1'b0;
      n++;
      if (memBusy_o == 1'b0) break;
    end
    memEn_i = 1'b0;
    @(negedge clk_i);
    if (sb.size() == 0) begin
      chk({name, ".sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk({name, ".ncyc"},  n, e.ncyc);
      chk({name, ".rd"},    {16'd0, rdData_o}, {16'd0, e.rd});
      chk({name, ".wr"},    {31'd0, memWr_o},    {31'd0, e.wr});
      chk({name, ".align"}, {31'd0, alignErr_o}, {31'd0, e.al});
      chk({name, ".berr"},  {31'd0, busErr_o},   {31'd0, e.er});
      chk({name, ".req_done"}, {31'd0, busReq_o}, 32'd0);
      chk({name, ".busy_done"}, {31'd0, memBusy_o}, 32'd0);
    end
    @(posedge clk_i); #1;
    @(negedge clk_i);
    chk({name, ".idle_wr"},   {31'd0, memWr_o},  32'd0);
    chk({name, ".idle_berr"}, {31'd0, busErr_o}, 32'd0);
    $display("[TB] %s done: rdData=%h n=%0d", name, rdData_o, n);
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk_i);
    chk("rst.req",  {31'd0, busReq_o},  32'd0);
    chk("rst.busy", {31'd0, memBusy_o}, 32'd0);
    chk("rst.rd",   {16'd0, rdData_o},  32'd0);
    chk("rst.be",   {30'd0, busBe_o},   32'd0);
    chk("rst.adr",  {16'd0, busAdr_o},  32'd0);
    arst_i = 1'b1;

    //      name   rw bo adr      wd       rdat     ack badr     be     bwd      cw rd       al er ncyc
    access("wrd",  0, 0, 16'h0040, 16'h0000, 16'hBEEF, 0, 16'h0040, 2'b11, 16'h0000, 0, 16'hBEEF, 0, 0, 1);
    access("bwr",  1, 1, 16'h0013, 16'h12A5, 16'h0000, 0, 16'h0012, 2'b10, 16'hA5A5, 1, 16'hBEEF, 0, 0, 1);
    access("brdh", 0, 1, 16'h0021, 16'h0000, 16'h7F80, 2, 16'h0020, 2'b10, 16'h0000, 0, 16'h007F, 0, 0, 3);
    access("brdl", 0, 1, 16'h0020, 16'h0000, 16'h7F80, 0, 16'h0020, 2'b01, 16'h0000, 0, 16'h0080, 0, 0, 1);
    access("tmo",  0, 0, 16'h0200, 16'h0000, 16'h0000, -1, 16'h0200, 2'b11, 16'h0000, 0, 16'h0000, 0, 1, 15);
    access("wrw",  0, 0, 16'h0300, 16'h0000, 16'h1234, 0, 16'h0300, 2'b11, 16'h0000, 0, 16'h1234, 0, 0, 1);
    access("ackto",0, 0, 16'h0400, 16'h0000, 16'h5A5A, 14, 16'h0400, 2'b11, 16'h0000, 0, 16'h5A5A, 0, 0, 15);
    access("mis",  1, 0, 16'h0101, 16'hC0DE, 16'h0000, 1, 16'h0100, 2'b11, 16'hC0DE, 1, 16'h5A5A, 1, 0, 2);
    access("bwl",  1, 1, 16'h0044, 16'h3C77, 16'h0000, 0, 16'h0044, 2'b01, 16'h7777, 1, 16'h5A5A, 0, 0, 1);

    // Reset two cycles into BUS
    @(posedge clk_i); #1;
    memEn_i = 1'b1; memRW_i = 1'b0; byteOp_i = 1'b0; adr_i = 16'h0500;
    @(posedge clk_i); @(posedge clk_i); @(posedge clk_i); #1;
    arst_i = 1'b0; memEn_i = 1'b0;
    #1;
    chk("arst.req",  {31'd0, busReq_o},  32'd0);
    chk("arst.busy", {31'd0, memBusy_o}, 32'd0);
    chk("arst.rd",   {16'd0, rdData_o},  32'd0);
    @(negedge clk_i);
    arst_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      chk("arst.nodone_wr",   {31'd0, memWr_o},  32'd0);
      chk("arst.nodone_berr", {31'd0, busErr_o}, 32'd0);
      chk("arst.idle_busy",   {31'd0, memBusy_o}, 32'd0);
    end
    access("post", 0, 0, 16'h0600, 16'h0000, 16'hA11C, 0, 16'h0600, 2'b11, 16'h0000, 0, 16'hA11C, 0, 0, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
